// File: rtl/fifo_read_port.sv
// Read-side port engine for the FIFO: issues takes to the controller and turns the
// synchronous-read memory stream into a backpressure-safe valid/ready output with a 2-entry buffer.
module fifo_read_port #(
  parameter int FIFO_DSIZE = 8,
  parameter int FIFO_ASIZE = 4
) (
  input  logic                  in_clock,
  input  logic                  in_reset_n,
  input  logic                  in_empty,
  output logic                  out_take,
  input  logic [FIFO_DSIZE-1:0] in_read_data,
  input  logic                  in_flush,
  output logic                  out_valid,
  input  logic                  in_ready,
  output logic [FIFO_DSIZE-1:0] out_data,
  output logic [1:0]            out_level
);

  logic [1:0]            count;
  logic                  inflight;
  logic [FIFO_DSIZE-1:0] head;
  logic [FIFO_DSIZE-1:0] tail;
  logic                  pop;
  logic [2:0]            credit;

  assign pop = out_valid & in_ready;

  // Free slots once this cycle's pop and the word already in flight are accounted for;
  // the pop term lets takes resume in the same cycle backpressure is released.
  always_comb begin
    credit = 3'd2 - {1'b0, count} - {2'b00, inflight} + {2'b00, pop};
  end

  assign out_take  = in_reset_n & ~in_flush & ~in_empty & (credit != 3'd0);
  assign out_valid = (count != 2'd0);
  assign out_data  = head;
  assign out_level = count;

  always_ff @(posedge in_clock or negedge in_reset_n) begin
    if (!in_reset_n) begin
      count    <= '0;
      inflight <= 1'b0;
    end else if (in_flush) begin
      count    <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= out_take;
      count    <= count + {1'b0, inflight} - {1'b0, pop};
    end
  end

  // Pop shifts tail into head first, then a capture lands in the slot after the last valid entry.
  always_ff @(posedge in_clock or negedge in_reset_n) begin
    if (!in_reset_n) begin
      head <= '0;
      tail <= '0;
    end else if (!in_flush) begin
      case ({pop, inflight})
        2'b10: head <= tail;
        2'b01: begin
          if (count == 2'd0) head <= in_read_data;
          else               tail <= in_read_data;
        end
        2'b11: begin
          if (count == 2'd1) begin
            head <= in_read_data;
          end else begin
            head <= tail;
            tail <= in_read_data;
          end
        end
        default: ;
      endcase
    end
  end

  // (count, inflight) = (2,1) would overflow the buffer; count = 3 is never encoded.
  assert property (@(posedge in_clock) disable iff (!in_reset_n)
    !(count == 2'd2 && inflight) && (count != 2'd3) && (FIFO_ASIZE > 0));

endmodule

// File: doc/fifo_read_port.md
# fifo_read_port

Read-side port engine for the FIFO. It sits between `fifo_controller` plus its synchronous-read memory and a downstream valid/ready consumer. It issues `take` requests to the controller only when `in_empty` is low and it has buffer space. It captures the memory word one cycle later into a 2-entry output buffer and presents words in FIFO order with full one-word-per-cycle throughput and no data loss under backpressure.

## Interface
- `FIFO_DSIZE`, default 8: data word width.
- `FIFO_ASIZE`, default 4: address width of the attached FIFO. Informational here; no pointer is kept in this block.
- `in_clock`  input  1: clock. All state updates on the rising edge.
- `in_reset_n`  input  1: reset, asynchronous, active-low.
- `in_empty`  input  1: empty flag from `fifo_controller`.
- `out_take`  output  1: take request to `fifo_controller`.
- `in_read_data`  input  `FIFO_DSIZE`: memory read data, valid the cycle after `out_take`.
- `in_flush`  input  1: synchronous discard of all buffered and in-flight words.
- `out_valid`  output  1: `out_data` holds a word.
- `in_ready`  input  1: consumer accepts `out_data` this cycle.
- `out_data`  output  `FIFO_DSIZE`: head word.
- `out_level`  output  2: buffered word count, 0..2.

## Operation
- **State**
  - 2-entry buffer: `head`/`tail` slots and `count` 0..2.
  - `inflight` bit, set the cycle after `out_take`.
- **Pop:** `pop = out_valid & in_ready`.
- **Take:** `credit = 2 - count - inflight + pop`.
  - `out_take = in_reset_n & ~in_flush & ~in_empty & (credit > 0)`.
  - Never asserted while `in_empty` is high.
- **Capture:** when `inflight` is 1, `in_read_data` is written at the clock edge.
  - Written into the slot after the last valid entry.
  - If a pop happens in the same cycle, the remaining entry shifts to `head` first, then the capture lands behind it.
- **Outputs:**
  - `out_valid = (count != 0)`.
  - `out_data = head`.
  - `out_level = count`.
- **Ordering:** words leave in exactly the order taken; no duplication, no drop.
- **Simultaneous events:** pop, capture and a new take may all occur in one cycle.
  - `count` next = `count + inflight - pop`, never exceeding 2 (guaranteed by `credit`).
- **`in_flush`:**
  - At the edge: `count` goes to 0 and `inflight` to 0. Any word arriving the next cycle from a take issued before the flush is ignored.
  - `out_take` is 0 during the flush cycle.
  - Words already taken from the controller are lost by design.
- **Reset:**
  - Asynchronous assertion forces `count=0`, `inflight=0`, `head=tail=0`.
  - Resulting outputs: `out_valid=0`, `out_take=0`, `out_data=0`, `out_level=0`.
  - Reset mid-transfer discards everything; the controller is reset on the same net.
- **No FSM enum.** State is the (`count`, `inflight`) pair. Legal combinations: (0,0) (0,1) (1,0) (1,1) (2,0). (2,1) is unreachable and must be asserted against.

## Timing
- **Read latency:** `out_take` high in cycle N, data on `in_read_data` in N+1, captured at the end of N+1, `out_valid` high in N+2.
- **First-word latency:** 2 cycles from `in_empty` falling to `out_valid` rising, with the buffer empty.
- **Throughput:** with `in_ready` held high and the FIFO non-empty, steady state is `count=1`, `inflight=1`, one pop and one take per cycle.
- **Backpressure:** with `in_ready` low, at most 2 words are buffered. `out_take` stops once `count + inflight = 2`. It resumes in the same cycle `in_ready` returns high, via the `pop` term in `credit`.
- **Combinational paths:** `out_take` depends on `in_empty`, `in_ready` and `in_flush`; there is no path to `out_data`.
- **`out_data`/`out_valid` stability:** stable while `out_valid=1` and `in_ready=0`.

## Test plan
- **Reset:** assert `in_reset_n=0` mid-stream with `count=2` -> immediately `out_valid=0`, `out_take=0`, `out_level=0`. After release with FIFO empty, `out_take` stays 0.
- **Single word:** write 0xA5, `in_ready=1` -> `out_take` one cycle; 0xA5 on `out_data` with `out_valid` for exactly one cycle, 2 cycles after `in_empty` falls.
- **Streaming:** 16 words 0x00..0x0F, `in_ready=1` -> 16 consecutive `out_valid` cycles in order, `out_take` high 16 consecutive cycles.
- **Backpressure:** 8 words, `in_ready=0` for 10 cycles -> `out_level=2`, exactly 2 takes. Release -> remaining 6 words in order, no gaps after refill.
- **Random `in_ready`:** 50% duty, 200 words -> scoreboard exact order match, `out_level` never 3, `out_take` never with `in_empty=1`.
- **Flush:** flush with `count=1` and `inflight=1` -> next cycle `out_valid=0`, and the late `in_read_data` word never appears. Subsequent words resume normally.
